// File: rtl/dot_seq_pkg.sv
// Shared types and constants for the sequential dot-product engine.
// Holds the operand-pair struct, the FSM state enum and the wrapping MAC helper.
package dot_seq_pkg;

    localparam int ACC_W = 9;
    localparam int CNT_W = 8;

    typedef struct packed {
        logic signed [8:0] sel1;
        logic signed [8:0] sel0;
    } product0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } DotState;

    // Product and sum are both kept to ACC_W bits, so overflow wraps in two's complement.
    function automatic logic [ACC_W-1:0] mac9(input logic [ACC_W-1:0] acc,
                                             input logic signed [8:0] x,
                                             input logic signed [8:0] y);
        logic [ACC_W-1:0] prod_lo;
        prod_lo = x * y;
        return acc + prod_lo;
    endfunction

endpackage

// File: rtl/dot_seq_mac_step.sv
// Combinational multiply-accumulate step: acc + x*y, truncated to ACC_W bits.
module mac_step
    import dot_seq_pkg::*;
(
    input  logic [ACC_W-1:0] acc,
    input  product0          pair,
    output logic [ACC_W-1:0] acc_next
);

    // Single wrapping MAC evaluation.
    always_comb begin
        acc_next = mac9(acc, pair.sel0, pair.sel1);
    end

endmodule

// File: rtl/dot_seq.sv
// Sequential dot product of LEN signed operand pairs with valid/ready handshakes.
// Outputs are registered from the next-state view so they never see out_ready combinationally.
module dot_seq
    import dot_seq_pkg::*;
#(
    parameter int unsigned LEN = 4
) (
    input  logic                    system1000,
    input  logic                    system1000_rstn,
    input  logic                    in_valid,
    input  product0                 in_pair,
    output logic                    in_ready,
    output logic                    out_valid,
    output logic signed [ACC_W-1:0] out_acc,
    input  logic                    out_ready,
    output logic                    busy
);

    DotState          state_r;
    DotState          state_nxt_s;
    logic [ACC_W-1:0] acc_r;
    logic [ACC_W-1:0] acc_nxt_s;
    logic [ACC_W-1:0] mac_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [ACC_W-1:0] out_acc_r;
    logic             busy_r;
    logic             in_ready_s;
    logic             out_valid_s;
    logic [ACC_W-1:0] out_acc_s;
    logic             busy_s;
    logic             pair_fire_s;
    logic             res_fire_s;

    assign pair_fire_s = in_valid & in_ready_r;
    assign res_fire_s  = out_valid_r & out_ready;

    mac_step u_mac_step (
        .acc      (acc_r),
        .pair     (in_pair),
        .acc_next (mac_s)
    );

    // State, accumulator, counter and output registers.
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            state_r     <= IDLE;
            acc_r       <= {ACC_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_acc_r   <= {ACC_W{1'b0}};
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            acc_r       <= acc_nxt_s;
            cnt_r       <= cnt_nxt_s;
            in_ready_r  <= in_ready_s;
            out_valid_r <= out_valid_s;
            out_acc_r   <= out_acc_s;
            busy_r      <= busy_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (pair_fire_s) begin
                    state_nxt_s = (LEN == 32'd1) ? DONE : ACC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACC: begin
                if (pair_fire_s && (cnt_r == CNT_W'(LEN - 32'd1))) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = ACC;
                end
            end
            DONE: begin
                if (res_fire_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Datapath update: clear on delivery, accumulate on accepted pair, otherwise hold.
    always_comb begin
        acc_nxt_s = acc_r;
        cnt_nxt_s = cnt_r;
        if (res_fire_s) begin
            acc_nxt_s = {ACC_W{1'b0}};
            cnt_nxt_s = {CNT_W{1'b0}};
        end else if (pair_fire_s) begin
            acc_nxt_s = mac_s;
            cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            acc_nxt_s = acc_r;
            cnt_nxt_s = cnt_r;
        end
    end

    // Output decode from the upcoming state, captured by the register block.
    always_comb begin
        in_ready_s  = 1'b1;
        out_valid_s = 1'b0;
        out_acc_s   = {ACC_W{1'b0}};
        busy_s      = 1'b0;
        case (state_nxt_s)
            IDLE: begin
                in_ready_s = 1'b1;
                busy_s     = 1'b0;
            end
            ACC: begin
                in_ready_s = 1'b1;
                busy_s     = 1'b1;
            end
            DONE: begin
                in_ready_s  = 1'b0;
                out_valid_s = 1'b1;
                out_acc_s   = acc_nxt_s;
                busy_s      = 1'b1;
            end
            default: begin
                in_ready_s = 1'b1;
                busy_s     = 1'b0;
            end
        endcase
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_acc   = out_acc_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_dot_seq.sv
// Directed self-checking bench for dot_seq: one LEN=4 instance and one LEN=1 instance.
module tb_dot_seq;
    import dot_seq_pkg::*;

    logic             clk;
    logic             rst_n;
    logic             a_in_valid;
    product0          a_in_pair;
    logic             a_in_ready;
    logic             a_out_valid;
    logic signed [8:0] a_out_acc;
    logic             a_out_ready;
    logic             a_busy;
    logic             b_in_valid;
    product0          b_in_pair;
    logic             b_in_ready;
    logic             b_out_valid;
    logic signed [8:0] b_out_acc;
    logic             b_out_ready;
    logic             b_busy;

    int checks;
    int errors;

    dot_seq #(.LEN(4)) u_dut4 (
        .system1000      (clk),
        .system1000_rstn (rst_n),
        .in_valid        (a_in_valid),
        .in_pair         (a_in_pair),
        .in_ready        (a_in_ready),
        .out_valid       (a_out_valid),
        .out_acc         (a_out_acc),
        .out_ready       (a_out_ready),
        .busy            (a_busy)
    );

    dot_seq #(.LEN(1)) u_dut1 (
        .system1000      (clk),
        .system1000_rstn (rst_n),
        .in_valid        (b_in_valid),
        .in_pair         (b_in_pair),
        .in_ready        (b_in_ready),
        .out_valid       (b_out_valid),
        .out_acc         (b_out_acc),
        .out_ready       (b_out_ready),
        .busy            (b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one pair to the LEN=4 instance, wait (bounded) for it to be taken.
    task automatic push(input int x, input int y);
        bit ok;
        ok = 1'b0;
        a_in_valid = 1'b1;
        a_in_pair.sel0 = 9'(x);
        a_in_pair.sel1 = 9'(y);
        for (int i = 0; i < 20 && !ok; i++) begin
            ok = a_in_ready;
            step();
        end
        a_in_valid = 1'b0;
        if (!ok) check("push_timeout", 0, 1);
    endtask

    initial begin
        int pat [7];
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        a_in_valid = 1'b0; a_in_pair = '0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_pair = '0; b_out_ready = 1'b1;
        #22;
        check("rst_in_ready", int'(a_in_ready), 1);
        check("rst_out_valid", int'(a_out_valid), 0);
        check("rst_out_acc", int'(a_out_acc), 0);
        check("rst_busy", int'(a_busy), 0);
        rst_n = 1'b1;
        step();

        // Basic product, back-to-back pairs.
        push(1, 2);
        check("busy_acc", int'(a_busy), 1);
        push(3, 4);
        push(-2, 5);
        check("no_early_valid", int'(a_out_valid), 0);
        push(0, 7);
        check("basic_valid", int'(a_out_valid), 1);
        check("basic_acc", int'(a_out_acc), 4);
        check("basic_in_ready_done", int'(a_in_ready), 0);
        step();
        check("basic_valid_drop", int'(a_out_valid), 0);
        check("basic_acc_clear", int'(a_out_acc), 0);
        check("basic_busy_idle", int'(a_busy), 0);

        // Product wrap: 16*16 = 256 -> -256.
        push(16, 16); push(0, 0); push(0, 0); push(0, 0);
        check("prod_wrap_acc", int'(a_out_acc), -256);
        step();

        // Sum wrap (255 + 1) while holding out_ready low with a pair offered.
        a_out_ready = 1'b0;
        push(15, 17); push(1, 1); push(0, 0); push(0, 0);
        a_in_valid = 1'b1;
        a_in_pair.sel0 = 9'(9);
        a_in_pair.sel1 = 9'(9);
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", int'(a_out_valid), 1);
            check("hold_acc", int'(a_out_acc), -256);
            check("hold_in_ready", int'(a_in_ready), 0);
            step();
        end
        a_in_valid = 1'b0;
        a_out_ready = 1'b1;
        step();
        check("hold_release", int'(a_out_valid), 0);
        push(1, 1); push(1, 1); push(1, 1); push(1, 1);
        check("hold_not_consumed", int'(a_out_acc), 4);
        step();

        // Bubbles: in_valid 1,0,0,1,0,1,1 with pair (3,3).
        pat = '{1, 0, 0, 1, 0, 1, 1};
        a_in_pair.sel0 = 9'(3);
        a_in_pair.sel1 = 9'(3);
        for (int i = 0; i < 7; i++) begin
            a_in_valid = pat[i][0];
            step();
            if (i < 6) check("bubble_no_valid", int'(a_out_valid), 0);
        end
        a_in_valid = 1'b0;
        check("bubble_valid", int'(a_out_valid), 1);
        check("bubble_acc", int'(a_out_acc), 36);
        step();

        // Reset mid-product discards the partial sum.
        push(5, 5); push(5, 5);
        check("pre_rst_busy", int'(a_busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", int'(a_busy), 0);
        check("midrst_in_ready", int'(a_in_ready), 1);
        step();
        check("midrst_busy_held", int'(a_busy), 0);
        #3;
        rst_n = 1'b1;
        step();
        push(1, 1); push(1, 1); push(1, 1); push(1, 1);
        check("post_rst_acc", int'(a_out_acc), 4);
        step();

        // LEN=1 stream: result every other cycle.
        b_in_pair.sel0 = 9'(2);
        b_in_pair.sel1 = 9'(3);
        b_in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("len1_valid", int'(b_out_valid), (i % 2 == 0) ? 1 : 0);
            check("len1_in_ready", int'(b_in_ready), (i % 2 == 0) ? 0 : 1);
            check("len1_acc", int'(b_out_acc), (i % 2 == 0) ? 6 : 0);
        end
        b_in_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
